// File: rtl/bcd_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_sub_pkg
//  Purpose  : Shared types and constants for the serial BCD subtractor:
//             FSM state encoding, the BCD digit type and the decimal radix.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_RADIX = 10;

endpackage : bcd_sub_pkg
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_sub
//  Purpose  : Combinational single-digit BCD subtract with borrow:
//             d = x - y - bin, corrected by +10 when negative.
//  Ports    : x, y  - BCD digits (minuend, subtrahend)
//             bin   - borrow in
//             d     - corrected result digit
//             bout  - borrow out
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
    import bcd_sub_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    // 5-bit signed covers the worst case 0 - 15 - 1 = -16 without wrap.
    logic signed [4:0] w_raw;
    logic signed [4:0] w_fix;

    always_comb begin
        w_raw = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
        w_fix = w_raw;
        bout  = 1'b0;
        if (w_raw < 0) begin
            w_fix = w_raw + 5'sd10;
            bout  = 1'b1;
        end
        d = w_fix[3:0];
    end

endmodule : bcd_digit_sub
`default_nettype wire

// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_subtractor_serial
//  Purpose  : Digit-serial packed-BCD subtractor producing |a-b| and a sign.
//             One digit per cycle in SUB; when the final borrow is set the
//             working result is ten's-complemented in CMP to get magnitude.
//  Ports    : clk, rst (sync, active-high)
//             start       - request, honoured only in IDLE
//             a, b        - packed BCD operands, digit 0 in bits [3:0]
//             busy        - high in SUB/CMP
//             done        - one-cycle result-valid pulse
//             diff,neg,err- result, held until the next done
//  Options  : BCD_SUB_INVALID_CHECK_EN - reject operands with digits > 9
//             (err=1, diff=0, done two cycles after start).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_subtractor_serial
    import bcd_sub_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q,  state_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     res_q,    res_d;
    logic [W-1:0]     diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             neg_q,    neg_d;
    logic [IDX_W-1:0] idx_q,    idx_d;

    logic [IDX_W+1:0] w_base;
    bcd_digit_t       w_x, w_y, w_d;
    logic             w_bout;

`ifdef BCD_SUB_INVALID_CHECK_EN
    logic err_q,      err_d;
    // Delays the invalid-operand done by one cycle inside DONE.
    logic inv_wait_q, inv_wait_d;

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // Shared digit subtractor: SUB computes a_i - b_i, CMP computes 0 - r_i.
    always_comb begin
        w_base = {idx_q, 2'b00};
        if (state_q == CMP) begin
            w_x = '0;
            w_y = res_q[w_base +: 4];
        end else begin
            w_x = a_q[w_base +: 4];
            w_y = b_q[w_base +: 4];
        end
    end

    bcd_digit_sub u_digit (
        .x    (w_x),
        .y    (w_y),
        .bin  (borrow_q),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        neg_d    = neg_q;
        idx_d    = idx_q;
`ifdef BCD_SUB_INVALID_CHECK_EN
        err_d      = err_q;
        inv_wait_d = inv_wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    idx_d    = '0;
`ifdef BCD_SUB_INVALID_CHECK_EN
                    if (has_invalid(a) || has_invalid(b)) begin
                        state_d    = DONE;
                        inv_wait_d = 1'b1;
                    end else begin
                        state_d = SUB;
                    end
`else
                    state_d = SUB;
`endif
                end
            end
            SUB, CMP: begin
                res_d[w_base +: 4] = w_d;
                borrow_d           = w_bout;
                idx_d              = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (state_q == SUB && w_bout) begin
                        // a < b: result is a ten's complement, fix it up.
                        state_d = CMP;
                    end else begin
                        // Outputs load here so they are valid during done.
                        state_d = DONE;
                        diff_d  = res_d;
                        neg_d   = (state_q == CMP);
`ifdef BCD_SUB_INVALID_CHECK_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            DONE: begin
`ifdef BCD_SUB_INVALID_CHECK_EN
                if (inv_wait_q) begin
                    inv_wait_d = 1'b0;
                    diff_d     = '0;
                    neg_d      = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            idx_q    <= idx_d;
        end
    end

`ifdef BCD_SUB_INVALID_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            inv_wait_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            inv_wait_q <= inv_wait_d;
        end
    end
    assign err  = err_q;
    assign done = (state_q == DONE) && !inv_wait_q;
`else
    assign err  = 1'b0;
    assign done = (state_q == DONE);
`endif

    assign busy = (state_q == SUB) || (state_q == CMP);
    assign diff = diff_q;
    assign neg  = neg_q;

endmodule : bcd_subtractor_serial
`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_subtractor_serial
//  Purpose  : Self-checking bench for bcd_subtractor_serial (DIGITS=4).
//             Expected results come from integer arithmetic on the decimal
//             values of the operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_subtractor_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int d = bcd2int(x) - bcd2int(y);
        return int2bcd(d < 0 ? -d : d);
    endfunction

    function automatic logic exp_neg(input logic [W-1:0] x, input logic [W-1:0] y);
        return bcd2int(x) < bcd2int(y);
    endfunction

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        return exp_neg(x, y) ? 2 * DIGITS + 1 : DIGITS + 1;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Issues one start (called just after a rising edge, DUT idle) and waits
    // for done. lat = cycles from start to done (0 on timeout).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output int bcyc);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcyc++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, neg, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h neg=%b err=%b, want all 0",
                     busy, done, diff, neg, err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h4321, 16'h0100, 16'h1234, 16'h9999};
        logic [W-1:0] vb [4] = '{16'h1234, 16'h0001, 16'h4321, 16'h9999};
        logic [W-1:0] wd [4] = '{16'h3087, 16'h0099, 16'h3087, 16'h0000};
        logic         wn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int           wl [4] = '{5, 5, 9, 5};
        int lat, bcyc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], lat, bcyc);
            checks++;
            if (lat !== wl[i]) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, wl[i]);
            end
            checks++;
            if (diff !== wd[i] || neg !== wn[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: got diff=%h neg=%b err=%b want diff=%h neg=%b err=0",
                         i, diff, neg, err, wd[i], wn[i]);
            end
            if (i == 0) begin
                checks++;
                if (bcyc !== 4) begin
                    errors++;
                    $display("FAIL dir0_busy_cycles: got %0d want 4", bcyc);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        int lat, bcyc;
        for (int n = 0; n < 30; n++) begin
            ra = rand_bcd();
            rb = (n % 7 == 0) ? ra : rand_bcd();
            run_op(ra, rb, lat, bcyc);
            checks++;
            if (lat !== exp_lat(ra, rb) || diff !== exp_diff(ra, rb) ||
                neg !== exp_neg(ra, rb) || err !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h: got lat=%0d diff=%h neg=%b err=%b want lat=%0d diff=%h neg=%b err=0",
                         n, ra, rb, lat, diff, neg, err, exp_lat(ra, rb),
                         exp_diff(ra, rb), exp_neg(ra, rb));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_during_busy();
        logic [W-1:0] oa = 16'h5000, ob = 16'h0321;
        int lat = 0, extra = 0;
        a = oa; b = ob; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin
                a = 16'h0001; b = 16'h0999; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (lat !== exp_lat(oa, ob) || diff !== exp_diff(oa, ob) || neg !== exp_neg(oa, ob)) begin
            errors++;
            $display("FAIL busy_restart: got lat=%0d diff=%h neg=%b want lat=%0d diff=%h neg=%b",
                     lat, diff, neg, exp_lat(oa, ob), exp_diff(oa, ob), exp_neg(oa, ob));
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_restart_spurious: got %0d busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1 = 16'h2000, b1 = 16'h0001;
        logic [W-1:0] a2 = 16'h0010, b2 = 16'h0500;
        logic [W-1:0] d1;
        int lat, bcyc, held_bad = 0, lat2 = 0;
        d1 = exp_diff(a1, b1);
        run_op(a1, b1, lat, bcyc);
        // Start in the done cycle with decoy operands: must be ignored.
        a = 16'h9999; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_start_ignored: got busy=%b done=%b want 0 0", busy, done);
        end
        a = a2; b = b2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat2 = c;
                break;
            end
            if (diff !== d1) held_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold: got %0d cycles with diff!=%h want 0", held_bad, d1);
        end
        checks++;
        if (lat2 !== exp_lat(a2, b2) || diff !== exp_diff(a2, b2) || neg !== exp_neg(a2, b2)) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d diff=%h neg=%b want lat=%0d diff=%h neg=%b",
                     lat2, diff, neg, exp_lat(a2, b2), exp_diff(a2, b2), exp_neg(a2, b2));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, diff, neg, err} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b diff=%h neg=%b err=%b want all 0",
                     busy, done, diff, neg, err);
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles want 0", dn);
        end
    endtask

    task automatic test_invalid();
        int lat, bcyc;
        run_op(16'h00A0, 16'h0000, lat, bcyc);
`ifdef BCD_SUB_INVALID_CHECK_EN
        checks++;
        if (lat !== 2 || err !== 1'b1 || diff !== '0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL invalid_check: got lat=%0d err=%b diff=%h neg=%b want lat=2 err=1 diff=0000 neg=0",
                     lat, err, diff, neg);
        end
`else
        checks++;
        if (lat !== DIGITS + 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_nocheck: got lat=%0d err=%b want lat=%0d err=0",
                     lat, err, DIGITS + 1);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_during_busy();
        test_back_to_back();
        test_reset_abort();
        test_invalid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_subtractor_serial
`default_nettype wire
